// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V control unit: instruction-phase FSM, latched decode, memory-wait
// timeout and sticky trap causes (illegal instruction, memory timeout).
module controle_multiciclo #(
  parameter int CNT_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int ENABLE_BNE  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] estado,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regiwrite,
  output logic       memwrite,
  output logic       memread,
  output logic       alusrc,
  output logic       memtoreg,
  output logic       branch,
  output logic       pcsrc,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic       timeout
);

  localparam logic [3:0] S_FETCH = 4'b0000;
  localparam logic [3:0] S_DECODE = 4'b0001;
  localparam logic [3:0] S_EXECUTE = 4'b0010;
  localparam logic [3:0] S_MEM = 4'b0011;
  localparam logic [3:0] S_WRITEBACK = 4'b1111;
  localparam logic [3:0] S_TRAP = 4'b1110;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LW, OP_SW: ok = (f3 == 3'b010);
      OP_ADDI:      ok = (f3 == 3'b000);
      OP_R: begin
        if (f7 == 7'b0000000) ok = (f3 != 3'b010) && (f3 != 3'b011);
        else if (f7 == 7'b0100000) ok = (f3 == 3'b000);
      end
      OP_BR:   ok = (f3 == 3'b000) || ((f3 == 3'b001) && (ENABLE_BNE != 0));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] alu_sel(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] sel;
    sel = 4'b0010;
    case (op)
      OP_ADDI: sel = 4'b0011;
      OP_BR:   sel = 4'b0110;
      OP_R: begin
        case (f3)
          3'b000:  sel = (f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
          3'b001:  sel = 4'b0111;
          3'b100:  sel = 4'b0100;
          3'b101:  sel = 4'b0101;
          3'b110:  sel = 4'b0001;
          3'b111:  sel = 4'b0000;
          default: sel = 4'b0010;
        endcase
      end
      default: sel = 4'b0010;
    endcase
    return sel;
  endfunction

  logic [3:0]       state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       op_q, f7_q;
  logic [2:0]       f3_q;
  logic             illegal_q, timeout_q;
  logic             mem_phase, wait_hit, imm_src;

  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  // The access that completes on the limit cycle wins over the timeout.
  assign wait_hit = mem_phase && !mem_ready && (cnt == CNT_LAST);
  assign imm_src = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      cnt       <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= nxt;
      if ((nxt != state) || mem_ready || !mem_phase) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
        f7_q <= funct7;
        if (nxt == S_TRAP) illegal_q <= 1'b1;
      end
      if (wait_hit) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: begin
        if (mem_ready) nxt = S_DECODE;
        else if (wait_hit) nxt = S_TRAP;
      end
      S_DECODE: nxt = is_legal(opcode, funct3, funct7) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (op_q == OP_BR) nxt = S_FETCH;
        else if ((op_q == OP_LW) || (op_q == OP_SW)) nxt = S_MEM;
        else nxt = S_WRITEBACK;
      end
      S_MEM: begin
        if (mem_ready) nxt = (op_q == OP_LW) ? S_WRITEBACK : S_FETCH;
        else if (wait_hit) nxt = S_TRAP;
      end
      S_WRITEBACK: nxt = S_FETCH;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_FETCH;
    endcase
  end

  // Reset masks every output combinationally so an in-flight store drops at once.
  always_comb begin
    estado     = reset ? S_FETCH : state;
    pcwrite    = 1'b0;
    irwrite    = 1'b0;
    regiwrite  = 1'b0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    alusrc     = 1'b0;
    memtoreg   = 1'b0;
    branch     = 1'b0;
    pcsrc      = 1'b0;
    alucontrol = 4'b0000;
    illegal    = illegal_q && !reset;
    timeout    = timeout_q && !reset;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          memread = 1'b1;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_EXECUTE: begin
          alucontrol = alu_sel(op_q, f3_q, f7_q);
          alusrc     = imm_src;
          if (op_q == OP_BR) begin
            branch  = 1'b1;
            pcsrc   = zero ^ f3_q[0];
            pcwrite = zero ^ f3_q[0];
          end
        end
        S_MEM: begin
          alucontrol = 4'b0010;
          alusrc     = 1'b1;
          memread    = (op_q == OP_LW);
          memwrite   = (op_q == OP_SW);
        end
        S_WRITEBACK: begin
          regiwrite  = 1'b1;
          memtoreg   = (op_q == OP_LW);
          alucontrol = alu_sel(op_q, f3_q, f7_q);
          alusrc     = imm_src;
        end
        default: ;
      endcase
    end
  end

endmodule
